// File: rtl/lca_pipe_adder.sv
// Pipelined carry-lookahead adder, binary or ones'-complement (end-around carry).
// Optional signed overflow output enabled by defining LCA_PIPE_OVERFLOW_EN.
`timescale 1ns/1ps

module lca_pipe_adder_cell #(
    parameter int N     = 4,
    parameter int GROUP = 4
) (
    input  logic [N-1:0] p,
    input  logic [N-1:0] g,
    input  logic         ci,
    output logic [N:0]   c
);

    logic acc;
    logic t;

    // Fully expanded lookahead inside each group, groups chained by their carry-in
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        t    = 1'b0;
        c[0] = ci;
        for (int b0 = 0; b0 < N; b0 += GROUP) begin
            for (int j = 0; j < GROUP; j++) begin
                if (b0 + j < N) begin
                    acc = c[b0];
                    for (int k = 0; k <= j; k++) begin
                        acc = acc & p[b0 + k];
                    end
                    for (int i = 0; i <= j; i++) begin
                        t = g[b0 + i];
                        for (int k = i + 1; k <= j; k++) begin
                            t = t & p[b0 + k];
                        end
                        acc = acc | t;
                    end
                    c[b0 + j + 1] = acc;
                end
            end
        end
    end

endmodule

module lca_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             ones_mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef LCA_PIPE_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NS = (STAGES < 1) ? 1 : STAGES;
    localparam int SW = WIDTH / NS;

    if (STAGES < 1 || (WIDTH % (GROUP * NS)) != 0) begin : g_bad_cfg
        $error("lca_pipe_adder: WIDTH must be a multiple of GROUP*STAGES, STAGES >= 1");
    end

    logic             adv;
    logic             m_valid_d, m_valid_q;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;

    assign adv     = ~m_valid_q | m_ready;
    assign s_ready = adv;

    for (genvar k = 0; k < NS; k++) begin : g_slice
        // operand bits not yet consumed when entering this slice
        localparam int RW = WIDTH - k * SW;

        logic [RW-1:0]    src_a, src_b;
        logic             src_v, src_om, src_c;
        logic [WIDTH-1:0] src_s;
        logic [SW-1:0]    sp, sg;
        logic [SW:0]      sc;
        logic             v_d, v_q;
        logic             om_d, om_q;
        logic             c_d, c_q;
        logic [WIDTH-1:0] s_d, s_q;

        if (k == 0) begin : g_src
            assign src_a  = a;
            assign src_b  = b;
            assign src_v  = s_valid;
            assign src_om = ones_mode;
            assign src_c  = cin & ~ones_mode;
            assign src_s  = '0;
        end else begin : g_src
            assign src_a  = g_slice[k-1].g_ops.a_q;
            assign src_b  = g_slice[k-1].g_ops.b_q;
            assign src_v  = g_slice[k-1].v_q;
            assign src_om = g_slice[k-1].om_q;
            assign src_c  = g_slice[k-1].c_q;
            assign src_s  = g_slice[k-1].s_q;
        end

        assign sp = src_a[SW-1:0] ^ src_b[SW-1:0];
        assign sg = src_a[SW-1:0] & src_b[SW-1:0];

        lca_pipe_adder_cell #(
            .N     (SW),
            .GROUP (GROUP)
        ) u_cell (
            .p  (sp),
            .g  (sg),
            .ci (src_c),
            .c  (sc)
        );

        // Merge this slice's sum bits into the running result
        always_comb begin
            v_d  = src_v;
            om_d = src_om;
            c_d  = sc[SW];
            s_d  = src_s;
            s_d[k*SW +: SW] = sp ^ sc[SW-1:0];
        end

        // Slice result register, advances with the global enable
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                v_q  <= 1'b0;
                om_q <= 1'b0;
                c_q  <= 1'b0;
                s_q  <= '0;
            end else if (adv) begin
                v_q  <= v_d;
                om_q <= om_d;
                c_q  <= c_d;
                s_q  <= s_d;
            end
        end

        if (k < NS - 1) begin : g_ops
            logic [RW-SW-1:0] a_d, a_q, b_d, b_q;

            // Skew the upper operand bits along with the slice
            always_comb begin
                a_d = src_a[RW-1:SW];
                b_d = src_b[RW-1:SW];
            end

            // Operand skew register
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef LCA_PIPE_OVERFLOW_EN
        if (k == NS - 1) begin : g_msb
            logic mc_d, mc_q;

            // Carry into the MSB, needed for signed overflow
            always_comb begin
                mc_d = sc[SW-1];
            end

            // MSB carry-in register
            always_ff @(posedge sys_clk or posedge sys_rst) begin
                if (sys_rst) begin
                    mc_q <= 1'b0;
                end else if (adv) begin
                    mc_q <= mc_d;
                end
            end
        end
`endif
    end

    logic [WIDTH-1:0] last_s;
    logic             last_v, last_om, last_c;
    logic             fold_ci;
    logic [WIDTH-1:0] fc;

    assign last_s  = g_slice[NS-1].s_q;
    assign last_v  = g_slice[NS-1].v_q;
    assign last_om = g_slice[NS-1].om_q;
    assign last_c  = g_slice[NS-1].c_q;
    assign fold_ci = last_c & last_om;

    // Incrementer: carries into every bit of raw sum + end-around carry
    lca_pipe_adder_cell #(
        .N     (WIDTH - 1),
        .GROUP (GROUP)
    ) u_fold (
        .p  (last_s[WIDTH-2:0]),
        .g  ('0),
        .ci (fold_ci),
        .c  (fc)
    );

    // End-around fold; carry out of the MSB is dropped, never a second wrap
    always_comb begin
        m_valid_d = last_v;
        sum_d     = last_s ^ fc;
        cout_d    = last_c;
    end

    // Output register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_valid_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
        end else if (adv) begin
            m_valid_q <= m_valid_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
        end
    end

    assign m_valid = m_valid_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

`ifdef LCA_PIPE_OVERFLOW_EN
    logic ovf_d, ovf_q;

    // Signed overflow, meaningless in ones' mode so forced low there
    always_comb begin
        ovf_d = ~last_om & (g_slice[NS-1].g_msb.mc_q ^ last_c);
    end

    // Overflow register aligned with sum
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
